// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch, decode, execute, memory
// and write-back over a shared ALU and a single unified memory port.
module mips_mc_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       jr_i,
  input  logic       eq_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b100;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EX_R     = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_JMP      = 4'd9,
    S_EX_I     = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   imm_alu_slt;

  // The immediate-ALU op is taken from the IR, which holds still from ID on.
  assign imm_alu_slt = (opcode_i == OP_SLTI);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = ALU_ADD;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    state_o      = state_q;

    case (state_q)
      S_IF: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'd1;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_d = S_ID;
      end
      S_ID: begin
        // Speculatively form the branch target into ALUOut.
        alu_src_b_o = 2'd3;
        case (opcode_i)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_EX_R;
          OP_BEQ:           state_d = S_BEQ;
          OP_J:             state_d = S_JMP;
          OP_ADDI, OP_SLTI: state_d = S_EX_I;
          default: begin
            state_d   = S_IF;
            illegal_o = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        if (opcode_i == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (opcode_i == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = S_IF;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) state_d = S_IF;
      end
      S_EX_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_d     = jr_i ? S_JR : S_R_WB;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = S_IF;
      end
      S_JR: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd3;
        state_d    = S_IF;
      end
      S_BEQ: begin
        pc_src_o   = 2'd1;
        pc_write_o = eq_i;
        state_d    = S_IF;
      end
      S_JMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd2;
        state_d    = S_IF;
      end
      S_EX_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = imm_alu_slt ? ALU_SLT : ALU_ADD;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        alu_op_o    = imm_alu_slt ? ALU_SLT : ALU_ADD;
        reg_write_o = 1'b1;
        state_d     = S_IF;
      end
      default: begin
        // Unreachable codes 13-15 recover to fetch with everything quiet.
        state_o = 4'd0;
        state_d = S_IF;
      end
    endcase

    // Reset silences every output and abandons any pending memory request.
    if (rst_i) begin
      state_d      = S_IF;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      i_or_d_o     = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 2'd0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'd0;
      alu_op_o     = ALU_ADD;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      illegal_o    = 1'b0;
      state_o      = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed, table-driven bench for mips_mc_ctrl: each record drives one cycle
// of inputs and lists the hand-computed outputs expected in that cycle.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       jr, eq, mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] opc;
    logic       jr;
    logic       eq;
    logic       rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  mips_mc_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .opcode_i     (opcode),
    .jr_i         (jr),
    .eq_i         (eq),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .i_or_d_o     (i_or_d),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .reg_write_o  (reg_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  // Field order: state, req, we, iord, irw, pcw, pcsrc, srca, srcb, aluop, rw, rdst, m2r, ill
  function automatic logic [20:0] pk(input int st, input int req, input int we, input int iod,
                                     input int irw, input int pcw, input int pcs, input int sa,
                                     input int sb, input int aop, input int rw, input int rd,
                                     input int m2r, input int ill);
    return {4'(st), 1'(req), 1'(we), 1'(iod), 1'(irw), 1'(pcw), 2'(pcs), 1'(sa),
            2'(sb), 3'(aop), 1'(rw), 1'(rd), 1'(m2r), 1'(ill)};
  endfunction

  function automatic logic [20:0] actualOut();
    return {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
            alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};
  endfunction

  task automatic checkOutput(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = actualOut();
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got state=%0d bits=%06h, expected state=%0d bits=%06h",
               name, act[20:17], act, exp[20:17], exp);
    end
    // Writing a register and the PC in the same cycle is never legal.
    assertCount++;
    if (pc_write && reg_write) begin
      failCount++;
      $display("[TB] FAIL %s: pc_write=%0b reg_write=%0b, required not both 1",
               name, pc_write, reg_write);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    opcode    = v.opc;
    jr        = v.jr;
    eq        = v.eq;
    mem_ready = v.rdy;
    #1;
    checkOutput(v.name, v.exp);
  endtask

  task automatic step(input string name, input logic r, input logic [5:0] opc,
                      input logic j, input logic e, input logic rdy, input logic [20:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.opc = opc; v.jr = j; v.eq = e; v.rdy = rdy; v.exp = exp;
    applyStimulus(v);
  endtask

  function automatic void add(input string name, input logic r, input logic [5:0] opc,
                              input logic j, input logic e, input logic rdy,
                              input logic [20:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.opc = opc; v.jr = j; v.eq = e; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; opcode = R; jr = 1'b0; eq = 1'b0; mem_ready = 1'b0;

    add("rst0",      1, R, 0, 0, 0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("rst1",      1, R, 0, 0, 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add("r_if_wait", 0, R, 0, 0, 0, pk(0,1,0,0,0,0,0,0,1,0,0,0,0,0));
    add("r_if",      0, R, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    add("r_id",      0, R, 0, 0, 1, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add("r_ex",      0, R, 0, 0, 0, pk(6,0,0,0,0,0,0,1,0,2,0,0,0,0));
    add("r_wb",      0, R, 0, 0, 0, pk(7,0,0,0,0,0,0,0,0,0,1,1,0,0));
    add("lw_if",     0, LW, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    add("lw_id",     0, LW, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add("lw_addr",   0, LW, 0, 0, 0, pk(2,0,0,0,0,0,0,1,2,0,0,0,0,0));
    add("lw_rd_w1",  0, LW, 0, 0, 0, pk(3,1,0,1,0,0,0,0,0,0,0,0,0,0));
    add("lw_rd_w2",  0, LW, 0, 0, 0, pk(3,1,0,1,0,0,0,0,0,0,0,0,0,0));
    add("lw_rd_w3",  0, LW, 0, 0, 0, pk(3,1,0,1,0,0,0,0,0,0,0,0,0,0));
    add("lw_rd",     0, LW, 0, 0, 1, pk(3,1,0,1,0,0,0,0,0,0,0,0,0,0));
    add("lw_wb",     0, LW, 0, 0, 1, pk(4,0,0,0,0,0,0,0,0,0,1,0,1,0));
    add("sw_if",     0, SW, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    add("sw_id",     0, SW, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add("sw_addr",   0, SW, 0, 0, 0, pk(2,0,0,0,0,0,0,1,2,0,0,0,0,0));
    add("sw_wr",     0, SW, 0, 0, 1, pk(5,1,1,1,0,0,0,0,0,0,0,0,0,0));
    add("addi_if",   0, ADDI, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    add("addi_id",   0, ADDI, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add("addi_ex",   0, ADDI, 0, 0, 0, pk(10,0,0,0,0,0,0,1,2,0,0,0,0,0));
    add("addi_wb",   0, ADDI, 0, 0, 0, pk(11,0,0,0,0,0,0,0,0,0,1,0,0,0));
    add("slti_if",   0, SLTI, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    add("slti_id",   0, SLTI, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add("slti_ex",   0, SLTI, 0, 0, 0, pk(10,0,0,0,0,0,0,1,2,4,0,0,0,0));
    add("slti_wb",   0, SLTI, 0, 0, 0, pk(11,0,0,0,0,0,0,0,0,4,1,0,0,0));
    add("j_if",      0, J, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    add("j_id",      0, J, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add("j_jmp",     0, J, 0, 0, 0, pk(9,0,0,0,0,1,2,0,0,0,0,0,0,0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // beq taken, then not taken; both return to fetch.
    step("beq1_if",  0, BEQ, 0, 1, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    step("beq1_id",  0, BEQ, 0, 1, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    step("beq1_br",  0, BEQ, 0, 1, 0, pk(8,0,0,0,0,1,1,0,0,0,0,0,0,0));
    step("beq0_if",  0, BEQ, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    step("beq0_id",  0, BEQ, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    step("beq0_br",  0, BEQ, 0, 0, 0, pk(8,0,0,0,0,0,1,0,0,0,0,0,0,0));

    // jr through EX_R into JR, no register write.
    step("jr_if",    0, R, 1, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    step("jr_id",    0, R, 1, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    step("jr_ex",    0, R, 1, 0, 0, pk(6,0,0,0,0,0,0,1,0,2,0,0,0,0));
    step("jr_jr",    0, R, 1, 0, 0, pk(12,0,0,0,0,1,3,0,0,0,0,0,0,0));

    // Illegal opcode pulses illegal in ID only, then fetch resumes.
    step("ill_if",   0, BAD, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    step("ill_id",   0, BAD, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,1));
    step("ill_back", 0, BAD, 0, 0, 0, pk(0,1,0,0,0,0,0,0,1,0,0,0,0,0));

    // Reset during a stalled store abandons the write.
    step("rsw_if",   0, SW, 0, 0, 1, pk(0,1,0,0,1,1,0,0,1,0,0,0,0,0));
    step("rsw_id",   0, SW, 0, 0, 0, pk(1,0,0,0,0,0,0,0,3,0,0,0,0,0));
    step("rsw_addr", 0, SW, 0, 0, 0, pk(2,0,0,0,0,0,0,1,2,0,0,0,0,0));
    step("rsw_wait", 0, SW, 0, 0, 0, pk(5,1,1,1,0,0,0,0,0,0,0,0,0,0));
    step("rsw_rst",  1, SW, 0, 0, 0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("rsw_post", 0, SW, 0, 0, 0, pk(0,1,0,0,0,0,0,0,1,0,0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
